// File: rtl/sreg_pkg.sv
// Shared types and sizing helpers for the serial shift-register transmit scheduler.
package sreg_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // Counter width for a down-counter spanning values 0..n-1 (never narrower than 1 bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 32'd2) ? 32'd1 : 32'(unsigned'($clog2(n)));
  endfunction

endpackage

// File: rtl/sreg_rr_arb2.sv
// Two-way round-robin grant; the last_grant pointer moves only when a word is accepted.
module sreg_rr_arb2 (
  input  logic       clk,
  input  logic       reset_al_in,
  input  logic [1:0] req_valid,
  input  logic       en,
  output logic       grant_c,
  output logic       accept_c
);

  logic last_grant_q;

  // On contention, favour whoever did not win last time.
  always_comb begin
    grant_c = 1'b0;
    if (&req_valid) grant_c = ~last_grant_q;
    else            grant_c = req_valid[1];
  end

  assign accept_c = en && (|req_valid);

  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in)  last_grant_q <= 1'b1;
    else if (accept_c) last_grant_q <= grant_c;
  end

endmodule

// File: rtl/sreg_tx_sched.sv
// Arbitrates two parallel requesters onto one MSB-first serial channel with a
// guaranteed inter-frame gap.
module sreg_tx_sched
  import sreg_pkg::*;
#(
  parameter int unsigned N   = 8,
  parameter int unsigned GAP = 1
) (
  input  logic         clk,
  input  logic         reset_al_in,
  input  logic         req0_valid,
  input  logic [N-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [N-1:0] req1_data,
  output logic         req1_ready,
  output logic         ser_out,
  output logic         ser_frame,
  output logic         ser_src,
  output logic         busy
);

  localparam int unsigned CNT_W = cnt_w(N);
  localparam int unsigned GAP_W = cnt_w(GAP + 32'd1);

  state_t             state_q, state_d;
  logic [N-1:0]       shift_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic               src_q;
  logic               grant_c;
  logic               accept_c;

  // Gating with reset keeps both readys low while reset is held.
  sreg_rr_arb2 u_arb (
    .clk         (clk),
    .reset_al_in (reset_al_in),
    .req_valid   ({req1_valid, req0_valid}),
    .en          ((state_q == S_IDLE) && reset_al_in),
    .grant_c     (grant_c),
    .accept_c    (accept_c)
  );

  assign req0_ready = accept_c && !grant_c;
  assign req1_ready = accept_c &&  grant_c;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_c) state_d = S_SHIFT;
      S_SHIFT: if (bit_cnt_q == '0) state_d = (GAP != 0) ? S_GAP : S_IDLE;
      S_GAP:   if (gap_cnt_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      src_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_c) begin
        shift_q   <= grant_c ? req1_data : req0_data;
        src_q     <= grant_c;
        bit_cnt_q <= CNT_W'(N - 32'd1);
      end
      if (state_q == S_SHIFT) begin
        shift_q <= {shift_q[N-2:0], 1'b0};
        if (bit_cnt_q != '0) bit_cnt_q <= bit_cnt_q - CNT_W'(1);
        else if (GAP != 0)   gap_cnt_q <= GAP_W'(GAP - 32'd1);
      end
      if (state_q == S_GAP && gap_cnt_q != '0) gap_cnt_q <= gap_cnt_q - GAP_W'(1);
    end
  end

  // Line outputs come straight from state and data registers.
  assign ser_frame = (state_q == S_SHIFT);
  assign ser_out   = ser_frame && shift_q[N-1];
  assign ser_src   = src_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sreg_tx_sched.sv
// Self-checking bench for sreg_tx_sched: vector table, directed corner cases and
// a frame scoreboard running over a randomized traffic phase.
module tb_sreg_tx_sched;

  localparam int unsigned N   = 8;
  localparam int unsigned GAP = 1;

  logic         clk = 1'b0;
  logic         reset_al_in;
  logic         req0_valid, req1_valid;
  logic [N-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready, ser_out, ser_frame, ser_src, busy;
  logic         g0_r0, g0_r1, g0_out, g0_frame, g0_src, g0_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sreg_tx_sched #(.N(N), .GAP(GAP)) dut (
    .clk(clk), .reset_al_in(reset_al_in),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .ser_out(ser_out), .ser_frame(ser_frame), .ser_src(ser_src), .busy(busy)
  );

  sreg_tx_sched #(.N(N), .GAP(0)) dut_g0 (
    .clk(clk), .reset_al_in(reset_al_in),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(g0_r0),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(g0_r1),
    .ser_out(g0_out), .ser_frame(g0_frame), .ser_src(g0_src), .busy(g0_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: words pushed on acceptance, popped and compared bit by bit on the line.
  typedef struct { logic src; logic [N-1:0] data; } word_t;
  word_t exp_q[$];
  word_t cur;
  int    bit_idx = 0;
  int    low_run = 1000;

  always @(negedge clk) begin
    if (!reset_al_in) begin
      exp_q.delete();
      bit_idx = 0;
      low_run = 1000;
    end else begin
      if (req0_ready && req1_ready) chk("both_ready", 32'd1, 32'd0);
      if (ser_frame) begin
        if (bit_idx == 0) begin
          chk("gap_ok", 32'(low_run >= int'(GAP) + 1), 32'd1);
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 32'd1, 32'd0);
            cur = '{src: ser_src, data: '0};
          end else begin
            cur = exp_q.pop_front();
          end
        end
        chk("sb_bit", 32'(ser_out), 32'(cur.data[N-1-bit_idx]));
        chk("sb_src", 32'(ser_src), 32'(cur.src));
        bit_idx = (bit_idx == int'(N) - 1) ? 0 : bit_idx + 1;
        low_run = 0;
      end else begin
        if (bit_idx != 0) begin
          chk("frame_short", 32'(bit_idx), 32'd0);
          bit_idx = 0;
        end
        low_run++;
      end
      if (req0_ready) exp_q.push_back('{src: 1'b0, data: req0_data});
      if (req1_ready) exp_q.push_back('{src: 1'b1, data: req1_data});
    end
  end

  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset_al_in = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    reset_al_in = 1'b1;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && bit_idx == 0) done = 1'b1;
    end
    chk("drain_timeout", 32'(done), 32'd1);
  endtask

  typedef struct {
    logic v0; logic [N-1:0] d0;
    logic r0; logic frame; logic out; logic busy;
  } vec_t;

  initial begin
    vec_t         tbl[12];
    logic [N-1:0] pat;
    int           rc0, rc1, nfr;
    logic         srcs[4];
    logic         prev_frame, took0, took1;

    reset_al_in = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;

    // Reset values
    @(negedge clk);
    chk("rst_ser_out", 32'(ser_out), 32'd0);
    chk("rst_ser_frame", 32'(ser_frame), 32'd0);
    chk("rst_ser_src", 32'(ser_src), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_r0", 32'(req0_ready), 32'd0);
    chk("rst_r1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    reset_al_in = 1'b1;

    // Single A5 frame from req0, table driven
    pat = 8'hA5;
    tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 1; i <= 8; i++) tbl[i] = '{1'b0, 8'h00, 1'b0, 1'b1, pat[8-i], 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      req0_valid = tbl[i].v0; req0_data = tbl[i].d0;
      @(negedge clk);
      chk($sformatf("t1_r0[%0d]", i), 32'(req0_ready), 32'(tbl[i].r0));
      chk($sformatf("t1_frame[%0d]", i), 32'(ser_frame), 32'(tbl[i].frame));
      chk($sformatf("t1_out[%0d]", i), 32'(ser_out), 32'(tbl[i].out));
      chk($sformatf("t1_busy[%0d]", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("t1_src[%0d]", i), 32'(ser_src), 32'd0);
    end

    // Both requesters continuously valid: sources alternate from req0
    do_reset();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 8'hFF;
    req1_valid = 1'b1; req1_data = 8'h00;
    rc0 = 0; rc1 = 0; nfr = 0; prev_frame = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      rc0 += int'(req0_ready);
      rc1 += int'(req1_ready);
      if (ser_frame && !prev_frame) begin
        if (nfr < 4) srcs[nfr] = ser_src;
        nfr++;
      end
      prev_frame = ser_frame;
    end
    chk("t2_nframes", 32'(nfr), 32'd4);
    chk("t2_r0_count", 32'(rc0), 32'd2);
    chk("t2_r1_count", 32'(rc1), 32'd2);
    for (int k = 0; k < 4; k++) chk($sformatf("t2_src[%0d]", k), 32'(srcs[k]), 32'(k % 2));
    drain();

    // GAP=0 instance, req1 only with 81: 8-cycle frames separated by one idle cycle
    do_reset();
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_data = 8'h81;
    pat = 8'h81;
    for (int c = 0; c < 19; c++) begin
      int m;
      m = c % 9;
      @(negedge clk);
      chk($sformatf("t3_r1[%0d]", c), 32'(g0_r1), 32'(m == 0));
      chk($sformatf("t3_frame[%0d]", c), 32'(g0_frame), 32'(m != 0));
      chk($sformatf("t3_busy[%0d]", c), 32'(g0_busy), 32'(m != 0));
      chk($sformatf("t3_out[%0d]", c), 32'(g0_out), (m != 0) ? 32'(pat[8-m]) : 32'd0);
      if (m != 0) chk($sformatf("t3_src[%0d]", c), 32'(g0_src), 32'd1);
    end
    drain();

    // Data changed during SHIFT must not disturb the frame in flight
    do_reset();
    pat = 8'h0F;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 8'h0F;
    @(negedge clk);
    chk("t4_accept", 32'(req0_ready), 32'd1);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      req0_data = 8'hF0;
      @(negedge clk);
      if (i <= 8) chk($sformatf("t4_out[%0d]", i), 32'(ser_out), 32'(pat[8-i]));
      chk($sformatf("t4_r0[%0d]", i), 32'(req0_ready), 32'(i == 10));
      chk($sformatf("t4_r1[%0d]", i), 32'(req1_ready), 32'd0);
    end
    drain();

    // Reset during bit 4 truncates asynchronously; req0 then wins the contention
    do_reset();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 8'h3C;
    @(negedge clk);
    chk("t5_accept", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("t5_pre_out", 32'(ser_out), 32'd1);
    reset_al_in = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h55;
    req1_valid = 1'b1; req1_data = 8'hAA;
    #1;
    chk("t5_async_frame", 32'(ser_frame), 32'd0);
    chk("t5_async_out", 32'(ser_out), 32'd0);
    chk("t5_async_busy", 32'(busy), 32'd0);
    chk("t5_rst_r0", 32'(req0_ready), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    reset_al_in = 1'b1;
    @(negedge clk);
    chk("t5_first_r0", 32'(req0_ready), 32'd1);
    chk("t5_first_r1", 32'(req1_ready), 32'd0);
    repeat (10) @(negedge clk);
    chk("t5_second_r1", 32'(req1_ready), 32'd1);
    drain();

    // Randomized traffic checked by the scoreboard
    do_reset();
    took0 = 1'b0; took1 = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (!req0_valid || took0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_data  = N'($urandom);
      end
      if (!req1_valid || took1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_data  = N'($urandom);
      end
      @(negedge clk);
      took0 = req0_ready;
      took1 = req1_ready;
    end
    drain();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
